pipe_decode_ctrl: RTL
=====================

PIPE_DECODE_CTRL -- requirements
Module: pipe_decode_ctrl

Interface
REQ-001 The block SHALL have parameter REG_AW, default 4, meaning the register-index width; register count is 2**REG_AW.
REQ-002 The block SHALL have parameter IMM_W, default 16, meaning the immediate width, 1..20; the immediate is taken from inst[8+IMM_W-1:8].
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the stall-counter width.
REQ-004 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-005 Port reset_n  input  1  is the asynchronous, active-low reset.
REQ-006 Port in_valid  input  1  means the fetch stage is presenting an instruction word.
REQ-007 Port in_inst  input  32  is the instruction word.
REQ-008 Port in_ready  output  1  means the decoder accepts in_inst this cycle.
REQ-009 Port out_valid  output  1  means the decoded bundle is valid.
REQ-010 Port out_ready  input  1  means the execute stage takes the bundle this cycle.
REQ-011 Port flush  input  1  means a taken branch or JAL in execute kills the held bundle.
REQ-012 Port wb_en / wb_rd  input  1 / REG_AW  means a writeback to register wb_rd completes.
REQ-013 Bundle outputs SHALL be: out_opcode 8; out_rd, out_rs1, out_rs2 REG_AW each; out_imm IMM_W; out_aluS 5; out_immSel, out_memOutSel 2 each; out_regFileEn, out_isLoad, out_isStore, out_isBranch, out_isJal, out_illegal 1 each.
REQ-014 Port stall_cnt  output  CNT_W  counts hazard-stall cycles.

Function
REQ-015 Decode SHALL use inst[3:0] as the class: 0000 ALU_R, 1000 ALU_I, 1001 LW, 0101 SW, 0010 CMP_R, 1010 CMP_I, 0110 BRANCH, 1011 JAL; any other value SHALL be illegal.
REQ-016 Field map: ALU_R/CMP_R: rd=[31:28], rs1=[27:24], rs2=[23:20]; ALU_I/CMP_I/LW/JAL: rd=[31:28], rs1=[27:24]; SW/BRANCH: rs1=[31:28], rs2=[27:24]; ALU_I with inst[7:4]=1011 (MVHI) SHALL read no sources.
REQ-017 aluS SHALL be {0,inst[7:4]} for ALU classes, {1,inst[7:4]} for CMP and BRANCH, and 0 otherwise.
REQ-018 immSel SHALL be 01 for I/LW/SW, 10 for JAL, and 00 otherwise.
REQ-019 memOutSel SHALL be 01 for LW, 10 for JAL, and 00 otherwise.
REQ-020 regFileEn SHALL be 1 for ALU, CMP, LW and JAL.
REQ-021 Fields a class does not use SHALL be driven 0, never held from a prior instruction.
REQ-022 An illegal instruction SHALL produce out_illegal=1 with regFileEn, isLoad, isStore, isBranch and isJal all 0.
REQ-023 Output stage SHALL be a two-state FSM, EMPTY/FULL, and out_valid SHALL equal (state==FULL).
REQ-024 Transfer in SHALL occur when in_valid&&in_ready; transfer out SHALL occur when out_valid&&out_ready.
REQ-025 Latency SHALL be one cycle: an instruction accepted at edge N is valid after edge N.
REQ-026 in_ready SHALL be (EMPTY || out_ready) && !hazard && !flush.
REQ-027 hazard SHALL be 1 when in_valid and a source register used by in_inst has its scoreboard bit set, or equals out_rd while out_valid&&out_regFileEn.
REQ-028 The scoreboard SHALL have 2**REG_AW bits.
REQ-029 A scoreboard bit SHALL be set on a transfer out with regFileEn, at index out_rd.
REQ-030 A scoreboard bit SHALL be cleared on wb_en, at index wb_rd.
REQ-031 On a simultaneous set and clear of the same index, set SHALL win; the hazard check SHALL use the registered scoreboard, with no bypass.
REQ-032 flush SHALL force the FSM to EMPTY next cycle, discard the held bundle without setting scoreboard bits, and accept nothing that cycle; flush overrides out_ready.
REQ-033 When FULL with out_ready=0, the bundle SHALL stay stable.
REQ-034 stall_cnt SHALL increment each cycle in_valid&&hazard holds, and SHALL saturate at 2**CNT_W-1.

Reset
REQ-035 With reset_n=0, the block SHALL asynchronously go EMPTY, clear the scoreboard and stall_cnt, and drive every bundle output to 0.
REQ-036 A bundle held or transferring when reset asserts SHALL be discarded.
REQ-037 After reset deasserts, in_ready SHALL be 1 if in_valid is 1 and flush is 0.

Verification
REQ-038 The bench SHALL check: 0x3120_0000 ALU_R add r3=r1+r2 -> next cycle out_valid=1, rd=3, rs1=1, rs2=2, aluS=00000, regFileEn=1.
REQ-039 The bench SHALL check: LW r4,8(r1) accepted, then ALU_R using r4 with out_ready=1, no wb -> in_ready=0 and stall_cnt increments; wb_en=1, wb_rd=4 -> accepted the cycle after.
REQ-040 The bench SHALL check: out_ready=0 for 3 cycles while FULL -> bundle unchanged, in_ready=0.
REQ-041 The bench SHALL check: flush while FULL with regFileEn, rd=5 -> EMPTY next cycle, scoreboard bit 5 stays 0.
REQ-042 The bench SHALL check: class 0x3 -> out_illegal=1, regFileEn=0; MVHI with rd=2, imm 0xABCD -> out_imm=0xABCD, rs1=rs2=0, no hazard check.
REQ-043 The bench SHALL check: reset_n pulsed low mid-stall -> all outputs 0 immediately, stall_cnt=0.

Source files
------------

// File: rtl/pipe_decode_ctrl_if.sv
// rtl/pipe_decode_ctrl_if.sv - fetch-in / decoded-bundle-out handshake bundle for pipe_decode_ctrl
//
// Signals:
//   in_valid, in_inst, in_ready       fetch stage offers an instruction word
//   out_valid, out_ready              decoded bundle handed to execute
//   out_opcode .. out_illegal         decoded bundle fields
// Modports:
//   master  the surrounding pipeline (drives in_valid/in_inst/out_ready)
//   slave   the decoder
interface pipe_decode_ctrl_if #(
    parameter int REG_AW = 4,
    parameter int IMM_W  = 16
);
    logic              in_valid;
    logic [31:0]       in_inst;
    logic              in_ready;

    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_opcode;
    logic [REG_AW-1:0] out_rd;
    logic [REG_AW-1:0] out_rs1;
    logic [REG_AW-1:0] out_rs2;
    logic [IMM_W-1:0]  out_imm;
    logic [4:0]        out_aluS;
    logic [1:0]        out_immSel;
    logic [1:0]        out_memOutSel;
    logic              out_regFileEn;
    logic              out_isLoad;
    logic              out_isStore;
    logic              out_isBranch;
    logic              out_isJal;
    logic              out_illegal;

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid,
        input  out_opcode, out_rd, out_rs1, out_rs2, out_imm, out_aluS,
        input  out_immSel, out_memOutSel, out_regFileEn, out_isLoad,
        input  out_isStore, out_isBranch, out_isJal, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid,
        output out_opcode, out_rd, out_rs1, out_rs2, out_imm, out_aluS,
        output out_immSel, out_memOutSel, out_regFileEn, out_isLoad,
        output out_isStore, out_isBranch, out_isJal, out_illegal
    );
endinterface

// File: rtl/pipe_decode_ctrl.sv
// rtl/pipe_decode_ctrl.sv - single-entry decode stage with register scoreboard and hazard stall
//
// Ports:
//   clk, reset_n     clock; asynchronous active-low reset
//   bus (slave)      fetch handshake in (in_valid/in_inst/in_ready) and decoded
//                    bundle out (out_valid/out_ready plus out_* fields)
//   flush            taken branch/JAL in execute: drop the held bundle
//   wb_en, wb_rd     writeback completed for register wb_rd
//   stall_cnt        saturating count of cycles an offered instruction hit a hazard
module pipe_decode_ctrl #(
    parameter int REG_AW = 4,
    parameter int IMM_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    pipe_decode_ctrl_if.slave bus,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int NREG = 2 ** REG_AW;

    localparam logic [3:0] CLS_ALU_R  = 4'b0000;
    localparam logic [3:0] CLS_ALU_I  = 4'b1000;
    localparam logic [3:0] CLS_LW     = 4'b1001;
    localparam logic [3:0] CLS_SW     = 4'b0101;
    localparam logic [3:0] CLS_CMP_R  = 4'b0010;
    localparam logic [3:0] CLS_CMP_I  = 4'b1010;
    localparam logic [3:0] CLS_BRANCH = 4'b0110;
    localparam logic [3:0] CLS_JAL    = 4'b1011;

    // ALU_I function that loads the immediate high half; it has no register source.
    localparam logic [3:0] FN_MVHI = 4'b1011;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0]        opcode;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [IMM_W-1:0]  imm;
        logic [4:0]        alu_s;
        logic [1:0]        imm_sel;
        logic [1:0]        mem_out_sel;
        logic              reg_file_en;
        logic              is_load;
        logic              is_store;
        logic              is_branch;
        logic              is_jal;
        logic              illegal;
    } bundle_t;

    state_t            state_q, state_d;
    bundle_t           bun_q, bun_d, dec;
    logic [NREG-1:0]   sb_q, sb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0]        cls;
    logic [3:0]        funct;
    logic [REG_AW-1:0] fld_hi;
    logic [REG_AW-1:0] fld_mid;
    logic [REG_AW-1:0] fld_lo;
    logic [IMM_W-1:0]  fld_imm;

    logic              use_rs1;
    logic              use_rs2;
    logic              busy_rs1;
    logic              busy_rs2;
    logic              hazard;
    logic              full;
    logic              in_ready;
    logic              xfer_in;
    logic              xfer_out;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    assign cls     = bus.in_inst[3:0];
    assign funct   = bus.in_inst[7:4];
    assign fld_hi  = REG_AW'(bus.in_inst[31:28]);
    assign fld_mid = REG_AW'(bus.in_inst[27:24]);
    assign fld_lo  = REG_AW'(bus.in_inst[23:20]);
    assign fld_imm = bus.in_inst[8+IMM_W-1:8];

    // ------------------------------------------------------------------
    // Decode: every field starts at zero so a class only carries what it uses.
    // ------------------------------------------------------------------
    always_comb begin
        dec        = '0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        dec.opcode = bus.in_inst[7:0];
        case (cls)
            CLS_ALU_R: begin
                dec.rd          = fld_hi;
                dec.rs1         = fld_mid;
                dec.rs2         = fld_lo;
                dec.alu_s       = {1'b0, funct};
                dec.reg_file_en = 1'b1;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
            end
            CLS_CMP_R: begin
                dec.rd          = fld_hi;
                dec.rs1         = fld_mid;
                dec.rs2         = fld_lo;
                dec.alu_s       = {1'b1, funct};
                dec.reg_file_en = 1'b1;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
            end
            CLS_ALU_I: begin
                dec.rd          = fld_hi;
                dec.imm         = fld_imm;
                dec.alu_s       = {1'b0, funct};
                dec.imm_sel     = 2'b01;
                dec.reg_file_en = 1'b1;
                if (funct != FN_MVHI) begin
                    dec.rs1 = fld_mid;
                    use_rs1 = 1'b1;
                end
            end
            CLS_CMP_I: begin
                dec.rd          = fld_hi;
                dec.rs1         = fld_mid;
                dec.imm         = fld_imm;
                dec.alu_s       = {1'b1, funct};
                dec.imm_sel     = 2'b01;
                dec.reg_file_en = 1'b1;
                use_rs1         = 1'b1;
            end
            CLS_LW: begin
                dec.rd          = fld_hi;
                dec.rs1         = fld_mid;
                dec.imm         = fld_imm;
                dec.imm_sel     = 2'b01;
                dec.mem_out_sel = 2'b01;
                dec.reg_file_en = 1'b1;
                dec.is_load     = 1'b1;
                use_rs1         = 1'b1;
            end
            CLS_SW: begin
                dec.rs1      = fld_hi;
                dec.rs2      = fld_mid;
                dec.imm      = fld_imm;
                dec.imm_sel  = 2'b01;
                dec.is_store = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            CLS_BRANCH: begin
                dec.rs1       = fld_hi;
                dec.rs2       = fld_mid;
                dec.imm       = fld_imm;
                dec.alu_s     = {1'b1, funct};
                dec.is_branch = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            CLS_JAL: begin
                dec.rd          = fld_hi;
                dec.rs1         = fld_mid;
                dec.imm         = fld_imm;
                dec.imm_sel     = 2'b10;
                dec.mem_out_sel = 2'b10;
                dec.reg_file_en = 1'b1;
                dec.is_jal      = 1'b1;
                use_rs1         = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard detection. A source is busy when its writer is already in
    // execute (scoreboard) or is the bundle sitting in our output register.
    // The registered scoreboard is used as-is: a writeback this cycle only
    // frees the register from the next cycle on.
    // ------------------------------------------------------------------
    assign full     = (state_q == S_FULL);
    assign busy_rs1 = sb_q[dec.rs1] || (full && bun_q.reg_file_en && (bun_q.rd == dec.rs1));
    assign busy_rs2 = sb_q[dec.rs2] || (full && bun_q.reg_file_en && (bun_q.rd == dec.rs2));
    assign hazard   = bus.in_valid && ((use_rs1 && busy_rs1) || (use_rs2 && busy_rs2));

    assign in_ready = (!full || bus.out_ready) && !hazard && !flush;
    assign xfer_in  = bus.in_valid && in_ready;
    // flush kills the held bundle even if execute was ready to take it.
    assign xfer_out = full && bus.out_ready && !flush;

    // ------------------------------------------------------------------
    // Output stage FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bun_d   = bun_q;
        case (state_q)
            S_EMPTY: begin
                if (xfer_in) begin
                    state_d = S_FULL;
                    bun_d   = dec;
                end
            end
            S_FULL: begin
                if (flush) begin
                    state_d = S_EMPTY;
                    bun_d   = '0;
                end else if (xfer_in) begin
                    // Back-to-back: the old bundle leaves as the new one lands.
                    bun_d = dec;
                end else if (xfer_out) begin
                    state_d = S_EMPTY;
                    bun_d   = '0;
                end
            end
            default: begin
                state_d = S_EMPTY;
                bun_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scoreboard: clear on writeback first so a same-index set wins.
    // ------------------------------------------------------------------
    always_comb begin
        sb_d = sb_q;
        if (wb_en) begin
            sb_d[wb_rd] = 1'b0;
        end
        if (xfer_out && bun_q.reg_file_en) begin
            sb_d[bun_q.rd] = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hazard && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bun_q <= '0;
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            bun_q <= bun_d;
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = full;
    assign bus.out_opcode    = bun_q.opcode;
    assign bus.out_rd        = bun_q.rd;
    assign bus.out_rs1       = bun_q.rs1;
    assign bus.out_rs2       = bun_q.rs2;
    assign bus.out_imm       = bun_q.imm;
    assign bus.out_aluS      = bun_q.alu_s;
    assign bus.out_immSel    = bun_q.imm_sel;
    assign bus.out_memOutSel = bun_q.mem_out_sel;
    assign bus.out_regFileEn = bun_q.reg_file_en;
    assign bus.out_isLoad    = bun_q.is_load;
    assign bus.out_isStore   = bun_q.is_store;
    assign bus.out_isBranch  = bun_q.is_branch;
    assign bus.out_isJal     = bun_q.is_jal;
    assign bus.out_illegal   = bun_q.illegal;
    assign stall_cnt         = cnt_q;

endmodule
